alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares the single combinational integer ALU between NREQ requesters (e.g. integer
//   issue and address generation). Uses round-robin arbitration with valid/ready on
//   each request port. Drives the ALU operand/opcode inputs from the granted requester.
//   Captures alu_result into a one-entry response register with valid/ready, id and tag.
//   Sits between the decode/issue stages and the ALU; adds one cycle of latency.
// PARAMETERS
//   NREQ   2    number of requesters (>=2); IDW = $clog2(NREQ)
//   TAGW   5    width of opaque per-request tag returned with the result
//   CNTW   32   width of the saturating stall counter
// PORTS
//   clk         in   1          clock, all state on rising edge
//   rstn        in   1          asynchronous active-low reset
//   req_valid   in   NREQ       request i valid
//   req_ready   out  NREQ       request i accepted this cycle (one-hot or zero)
//   req_aluop   in   4*NREQ     ALUOp of requester i in bits [4i+3:4i]
//   req_op1     in   32*NREQ    operand 1 of requester i in bits [32i+31:32i]
//   req_op2     in   32*NREQ    operand 2 of requester i
//   req_tag     in   TAGW*NREQ  tag of requester i
//   alu_op      out  4          to ALU ALUOp
//   alu_op1     out  32         to ALU op1
//   alu_op2     out  32         to ALU op2
//   alu_result  in   32         from ALU, combinational on alu_op/op1/op2
//   resp_valid  out  1          response register holds a result
//   resp_ready  in   1          consumer takes response this cycle
//   resp_data   out  32         captured ALU result
//   resp_id     out  IDW        index of the requester that issued it
//   resp_tag    out  TAGW       tag of that request
//   stall_cnt   out  CNTW       cycles with any req_valid but can_issue==0, saturating
// BEHAVIOUR
//   Reset (async, rstn=0):
//     resp_valid=0; resp_data=0; resp_id=0; resp_tag=0; stall_cnt=0; rr pointer ptr=0.
//     req_ready=0 while rstn=0.
//     An in-flight response is discarded immediately.
//   Issue and grant:
//     - can_issue = !resp_valid || resp_ready (single-entry register, drain+fill same cycle).
//     - Grant g = first i with req_valid[i], searching ptr, ptr+1, ... cyclically mod NREQ.
//     - req_ready[g] = can_issue (combinational); all other req_ready bits are 0.
//     - req_ready=0 when no req_valid.
//   ALU drive:
//     - alu_op/op1/op2 = payload of g whenever any req_valid is asserted.
//     - Otherwise they are requester 0 payload, which is don't-care.
//   Handshake (req_valid[g] && req_ready[g]) at edge:
//     - resp_valid<=1; resp_data<=alu_result; resp_id<=g; resp_tag<=req_tag[g].
//     - ptr <= (g==NREQ-1) ? 0 : g+1.
//   No handshake:
//     - ptr unchanged.
//     - resp_valid<=0 if resp_ready was high, else resp_* held stable.
//   Latency and throughput:
//     - Latency is exactly 1 cycle from handshake to resp_valid.
//     - Throughput is 1 result per cycle when resp_ready is held high.
//   Requester rules:
//     - Once req_valid is high, it holds valid and payload stable until ready.
//     - req_valid must not depend on req_ready.
//   Consumer backpressure: resp_* are stable while resp_valid && !resp_ready.
//   Fairness: a continuously valid requester is granted within NREQ handshakes.
//   ALUOp: opcode values are not checked; undefined ALUOp returns whatever the ALU gives (0).
//   Stall counter: stall_cnt += 1 when |req_valid && !can_issue; holds at 2^CNTW-1.
// TESTING
//   - Reset with all req_valid=1 -> req_ready=0, resp_valid=0, stall_cnt=0.
//     Release rstn -> requester 0 granted first.
//   - Single request: req0 ADD(0011) 5,7, tag 3; resp_ready=1.
//     -> resp_valid next cycle, resp_data=12, resp_id=0, resp_tag=3.
//   - Both requesters valid continuously, resp_ready=1, 6 cycles -> grants 0,1,0,1,0,1.
//     A back-to-back result appears every cycle.
//   - Hold resp_ready=0 for 3 cycles with req1 SUB 3-5 pending.
//     -> resp_data=0xFFFFFFFE held stable; req_ready=0; stall_cnt=3.
//     Raise resp_ready -> same-cycle drain+fill.
//   - Assert rstn=0 mid-stream while resp_valid=1 -> resp_valid drops asynchronously.
//     ptr=0 after release.
//   - Opcodes SLT(1000) -1<1 -> resp_data=1; SRA(0010) 0x80000000>>>4 -> 0xF8000000.
//     Undefined op 1111 -> resp_data=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters; result captured with id/tag.
// Latency: 1 cycle from request handshake to resp_valid; 1 result/cycle with resp_ready held high.
// Backpressure: req_ready drops while the response register is full and not draining; resp_* held stable.
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int TAGW = 5,
  parameter int CNTW = 32,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_aluop,
  input  logic [32*NREQ-1:0]   req_op1,
  input  logic [32*NREQ-1:0]   req_op2,
  input  logic [TAGW*NREQ-1:0] req_tag,
  output logic [3:0]           alu_op,
  output logic [31:0]          alu_op1,
  output logic [31:0]          alu_op2,
  input  logic [31:0]          alu_result,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic [IDW-1:0]       resp_id,
  output logic [TAGW-1:0]      resp_tag,
  output logic [CNTW-1:0]      stall_cnt
);

  localparam logic [IDW:0] NREQ_X = (IDW+1)'(NREQ);

  logic           any_valid;
  logic           can_issue;
  logic           hs;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt;
  logic [IDW:0]   idx;
  logic [IDW-1:0] idx_n;
  logic [TAGW-1:0] gnt_tag;

  assign any_valid = |req_valid;
  // Single-entry response register can refill in the same cycle it drains.
  assign can_issue = !resp_valid || resp_ready;
  assign hs        = |(req_valid & req_ready);

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    idx_n = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= NREQ_X) begin
        idx = idx - NREQ_X;
      end
      idx_n = idx[IDW-1:0];
      // Scanning from the far end down lets the closest valid requester win last.
      if (req_valid[idx_n]) begin
        gnt = idx_n;
      end
    end
  end

  // One-hot ready to the granted requester; forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = rstn && any_valid && can_issue && (gnt == IDW'(i));
    end
  end

  // Steer the granted payload onto the ALU; requester 0 when idle (don't-care).
  always_comb begin
    alu_op  = req_aluop[3:0];
    alu_op1 = req_op1[31:0];
    alu_op2 = req_op2[31:0];
    gnt_tag = req_tag[TAGW-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (any_valid && gnt == IDW'(i)) begin
        alu_op  = req_aluop[i*4 +: 4];
        alu_op1 = req_op1[i*32 +: 32];
        alu_op2 = req_op2[i*32 +: 32];
        gnt_tag = req_tag[i*TAGW +: TAGW];
      end
    end
  end

  // Response register and round-robin pointer: fill on handshake, clear on drain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_tag   <= '0;
      ptr        <= '0;
    end else if (hs) begin
      resp_valid <= 1'b1;
      resp_data  <= alu_result;
      resp_id    <= gnt;
      resp_tag   <= gnt_tag;
      if (gnt == IDW'(NREQ - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= gnt + IDW'(1);
      end
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  // Saturating count of cycles where work is waiting but the response slot is blocked.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (any_valid && !can_issue && stall_cnt != {CNTW{1'b1}}) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed requests, scoreboard queue of expected responses.
// A negedge monitor pops and compares every consumed response; stimulus checks handshakes/counters.
// A local combinational ALU model stands in for the real ALU.
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int TAGW = 5;
  localparam int CNTW = 32;
  localparam int IDW  = 1;

  logic                 clk;
  logic                 rstn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [4*NREQ-1:0]    req_aluop;
  logic [32*NREQ-1:0]   req_op1;
  logic [32*NREQ-1:0]   req_op2;
  logic [TAGW*NREQ-1:0] req_tag;
  logic [3:0]           alu_op;
  logic [31:0]          alu_op1;
  logic [31:0]          alu_op2;
  logic [31:0]          alu_result;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_data;
  logic [IDW-1:0]       resp_id;
  logic [TAGW-1:0]      resp_tag;
  logic [CNTW-1:0]      stall_cnt;

  int checks   = 0;
  int failures = 0;

  logic [37:0] exp_q[$];
  logic [37:0] mon_e;

  alu_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .CNTW(CNTW), .IDW(IDW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_aluop  (req_aluop),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_tag    (req_tag),
    .alu_op     (alu_op),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_result (alu_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_tag   (resp_tag),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: AND, OR, SRA, ADD, SUB, SLT; anything else yields 0.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      4'b0010: alu_result = $signed(alu_op1) >>> alu_op2[4:0];
      4'b0011: alu_result = alu_op1 + alu_op2;
      4'b0100: alu_result = alu_op1 - alu_op2;
      4'b1000: alu_result = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg);
    req_valid[i]          = v;
    req_aluop[i*4 +: 4]   = op;
    req_op1[i*32 +: 32]   = a;
    req_op2[i*32 +: 32]   = b;
    req_tag[i*TAGW +: TAGW] = tg;
  endtask

  task automatic push(input logic [31:0] d, input logic [IDW-1:0] id, input logic [4:0] tg);
    exp_q.push_back({d, id, tg});
  endtask

  // Monitor: every response taken by the consumer must match the head of the queue.
  always @(negedge clk) begin
    if (rstn && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected actual=%h expected=none", {resp_data, resp_id, resp_tag});
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp", {26'd0, resp_data, resp_id, resp_tag}, {26'd0, mon_e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rstn       = 1'b0;
    resp_ready = 1'b0;
    req_valid  = '0;
    req_aluop  = '0;
    req_op1    = '0;
    req_op2    = '0;
    req_tag    = '0;
    set_req(0, 1'b1, 4'b0011, 32'd5, 32'd7, 5'd3);
    set_req(1, 1'b1, 4'b0011, 32'd1, 32'd2, 5'd9);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);

    // Release: requester 0 first, then requester 1.
    resp_ready = 1'b1;
    rstn       = 1'b1;
    #1;
    chk("first_grant", 64'(req_ready), 64'b01);
    push(32'd12, 1'b0, 5'd3);
    step();
    req_valid[0] = 1'b0;
    push(32'd3, 1'b1, 5'd9);
    @(negedge clk);
    chk("latency_valid", 64'(resp_valid), 64'd1);
    chk("second_grant", 64'(req_ready), 64'b10);
    step();
    req_valid[1] = 1'b0;
    step();

    // Both requesters continuously valid: alternate grants, one result per cycle.
    set_req(0, 1'b1, 4'b0011, 32'd10, 32'd20, 5'd1);
    set_req(1, 1'b1, 4'b0100, 32'd100, 32'd1, 5'd2);
    for (int i = 0; i < 3; i++) begin
      push(32'd30, 1'b0, 5'd1);
      push(32'd99, 1'b1, 5'd2);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      chk("b2b_valid", 64'(resp_valid), 64'd1);
    end
    req_valid = '0;
    step();
    @(negedge clk);
    chk("idle_valid", 64'(resp_valid), 64'd0);

    // Backpressure: SUB result held while req0 stalls.
    set_req(1, 1'b1, 4'b0100, 32'd3, 32'd5, 5'd7);
    push(32'hFFFF_FFFE, 1'b1, 5'd7);
    step();
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 4'b0011, 32'd4, 32'd4, 5'd5);
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_data_hold", 64'(resp_data), 64'hFFFF_FFFE);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      step();
    end
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd3);
    resp_ready = 1'b1;
    #1;
    chk("drain_fill_ready", 64'(req_ready), 64'b01);
    push(32'd8, 1'b0, 5'd5);
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("drain_fill_valid", 64'(resp_valid), 64'd1);
    chk("stall_hold", 64'(stall_cnt), 64'd3);
    step();

    // Mid-stream reset discards the held response and returns ptr to 0.
    set_req(0, 1'b1, 4'b0011, 32'd1, 32'd1, 5'd4);
    resp_ready = 1'b0;
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(resp_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(resp_valid), 64'd0);
    chk("async_rst_data", 64'(resp_data), 64'd0);
    chk("async_rst_stall", 64'(stall_cnt), 64'd0);
    set_req(0, 1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd1, 5'd10);
    set_req(1, 1'b1, 4'b0010, 32'h8000_0000, 32'd4, 5'd11);
    #1;
    chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    resp_ready = 1'b1;
    rstn       = 1'b1;
    #1;
    chk("ptr_after_rst", 64'(req_ready), 64'b01);
    push(32'd1, 1'b0, 5'd10);
    push(32'hF800_0000, 1'b1, 5'd11);
    step();
    req_valid[0] = 1'b0;
    step();
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 4'b1111, 32'd9, 32'd9, 5'd12);
    push(32'd0, 1'b0, 5'd12);
    step();
    req_valid[0] = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      step();
    end
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
